// File: rtl/ram_b_responder_if.sv
// Request/response bus between board-level request logic and the RAM_B responder.
interface ram_b_responder_if #(
  parameter int ADDR_W = 6
);
  logic              req;
  logic              req_write;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_w_data;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_r_data;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req, req_write, req_addr, req_size, req_w_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_r_data, rsp_err, init_done
  );

  modport slave (
    input  req, req_write, req_addr, req_size, req_w_data, rsp_ready,
    output req_ready, rsp_valid, rsp_r_data, rsp_err, init_done
  );
endinterface

// File: rtl/ram_b_responder.sv
// Responder for the DEPTH x 32-bit RAM_B store: byte/half/word access with one response per request.
// Define RAM_B_INIT_EN to fill word i with {4{i}} after every reset before requests are accepted.
module ram_b_responder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  ram_b_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RESP} state_t;

`ifdef RAM_B_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t state, state_nxt;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              accept;
  logic              req_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       rd_word_p0;
  logic [1:0]        lane_p0;
  logic [1:0]        size_p0;
  logic              wr_p0;
  logic              err_p0;
  logic              vld_p0;

`ifdef RAM_B_INIT_EN
  logic [ADDR_W-1:0] init_cnt;
`endif

  function automatic logic size_err(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return ln[0];
      2'b10:   return (ln != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'b00:   return 4'b0001 << ln;
      2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the right-aligned data lets the lane mask alone pick the target bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] ln);
    case (size)
      2'b00:   return {24'b0, word[{ln, 3'b000} +: 8]};
      2'b01:   return {16'b0, word[{ln[1], 4'b0000} +: 16]};
      default: return word;
    endcase
  endfunction

  assign word_idx      = bus.req_addr[ADDR_W+1:2];
  assign lane          = bus.req_addr[1:0];
  assign req_err       = size_err(bus.req_size, lane);
  assign bus.req_ready = (state == ST_IDLE) && !rst;
  assign accept        = bus.req && bus.req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef RAM_B_INIT_EN
      ST_INIT: if (&init_cnt) state_nxt = ST_IDLE;
`endif
      ST_IDLE: if (accept) state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = accept && bus.req_write && !req_err;
    mem_waddr = word_idx;
    mem_wdata = lane_data(bus.req_size, bus.req_w_data);
    mem_be    = lane_mask(bus.req_size, lane);
`ifdef RAM_B_INIT_EN
    if (state == ST_INIT) begin
      mem_we    = !rst;
      mem_waddr = init_cnt;
      mem_wdata = {4{8'(init_cnt)}};
      mem_be    = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RST_STATE;
      wr_p0  <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_p0  <= bus.req_write;
        err_p0 <= req_err;
      end
    end
  end

`ifdef RAM_B_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end
`endif

  // Stage p0: accept edge captures the pre-write array word and the access shape.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_p0 <= mem[word_idx];
      lane_p0    <= lane;
      size_p0    <= bus.req_size;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) begin
        mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Response outputs are gated by state so reset clears them without resetting the data registers.
  assign vld_p0         = (state == ST_RESP);
  assign bus.rsp_valid  = vld_p0;
  assign bus.rsp_err    = vld_p0 && err_p0;
  assign bus.rsp_r_data = (vld_p0 && !wr_p0 && !err_p0) ? lane_extract(rd_word_p0, size_p0, lane_p0)
                                                         : 32'b0;

`ifdef RAM_B_INIT_EN
  assign bus.init_done = (state != ST_INIT);
`else
  assign bus.init_done = 1'b1;
`endif
endmodule

// File: tb/tb_ram_b_responder.sv
// Directed and randomized bench for ram_b_responder against a byte-level array model.
module tb_ram_b_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] ref_mem [64];

  ram_b_responder_if #(.ADDR_W(6)) bus ();

  ram_b_responder #(.ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level model: an access touches 1, 2 or 4 consecutive bytes starting at the lane.
  function automatic void model(input logic wr, input logic [7:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int w = int'(a[7:2]);
    int l = int'(a[1:0]);
    int nb;
    er = (sz == 2'd3) || (sz == 2'd1 && (l % 2) != 0) || (sz == 2'd2 && l != 0);
    rd = 32'b0;
    if (er) return;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < nb; k++) begin
      if (wr) ref_mem[w][8*(l+k) +: 8] = wd[8*k +: 8];
      else    rd[8*k +: 8] = ref_mem[w][8*(l+k) +: 8];
    end
  endfunction

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input int stall, input logic pulse,
                        output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    check("rsp_valid_before_accept", {31'b0, bus.rsp_valid}, 32'd0);
    bus.req = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_size = sz; bus.req_w_data = wd;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("rsp_valid_latency1", {31'b0, bus.rsp_valid}, 32'd1);
    rd = bus.rsp_r_data;
    er = bus.rsp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("stall_rsp_r_data", bus.rsp_r_data, rd);
      check("stall_rsp_err", {31'b0, bus.rsp_err}, {31'b0, er});
      check("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
      if (pulse) begin
        bus.req = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h04;
        bus.req_size = 2'd2; bus.req_w_data = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk);
    bus.req = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_consume", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic op(input logic wr, input logic [7:0] a, input logic [1:0] sz,
                    input logic [31:0] wd, input int stall, input logic pulse,
                    output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    model(wr, a, sz, wd, erd, eer);
    do_req(wr, a, sz, wd, stall, pulse, rd, er);
    check("rsp_r_data", rd, erd);
    check("rsp_err", {31'b0, er}, {31'b0, eer});
  endtask

  task automatic wait_init();
`ifdef RAM_B_INIT_EN
    int cyc = 0;
    while (!bus.init_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("init_cycles", cyc, 32'd64);
    for (int i = 0; i < 64; i++) ref_mem[i] = {4{8'(i)}};
`endif
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_w_data = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_r_data", bus.rsp_r_data, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
`ifdef RAM_B_INIT_EN
    check("rst_init_done", {31'b0, bus.init_done}, 32'd0);
`else
    check("rst_init_done", {31'b0, bus.init_done}, 32'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifndef RAM_B_INIT_EN
    check("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
`endif
    wait_init();

    // Give every word a defined value so random reads are comparable.
    for (int i = 0; i < 64; i++) op(1'b1, 8'(i * 4), 2'd2, $urandom, 0, 1'b0, rd, er);

    op(1'b1, 8'h04, 2'd2, 32'h1234_5678, 0, 1'b0, rd, er);
    op(1'b0, 8'h04, 2'd2, 32'h0, 0, 1'b0, rd, er);
    check("word_read_04", rd, 32'h1234_5678);
    op(1'b0, 8'h04, 2'd0, 32'h0, 0, 1'b0, rd, er); check("byte_04", rd, 32'h78);
    op(1'b0, 8'h05, 2'd0, 32'h0, 0, 1'b0, rd, er); check("byte_05", rd, 32'h56);
    op(1'b0, 8'h06, 2'd0, 32'h0, 0, 1'b0, rd, er); check("byte_06", rd, 32'h34);
    op(1'b0, 8'h07, 2'd0, 32'h0, 0, 1'b0, rd, er); check("byte_07", rd, 32'h12);
    op(1'b0, 8'h06, 2'd1, 32'h0, 0, 1'b0, rd, er); check("half_06", rd, 32'h1234);
    op(1'b1, 8'h05, 2'd0, 32'hFFFF_FFAB, 0, 1'b0, rd, er);
    op(1'b0, 8'h04, 2'd2, 32'h0, 0, 1'b0, rd, er); check("after_byte_wr", rd, 32'h1234_AB78);
    op(1'b1, 8'h04, 2'd1, 32'hFFFF_BEEF, 0, 1'b0, rd, er);
    op(1'b0, 8'h04, 2'd2, 32'h0, 0, 1'b0, rd, er); check("after_half_wr", rd, 32'h1234_BEEF);

    op(1'b0, 8'h06, 2'd2, 32'h0, 0, 1'b0, rd, er); check("err_word_06", {31'b0, er}, 32'd1);
    op(1'b0, 8'h05, 2'd1, 32'h0, 0, 1'b0, rd, er); check("err_half_05", {31'b0, er}, 32'd1);
    op(1'b0, 8'h00, 2'd3, 32'h0, 0, 1'b0, rd, er); check("err_size3", {31'b0, er}, 32'd1);
    check("err_size3_data", rd, 32'd0);
    op(1'b1, 8'h05, 2'd2, 32'hFFFF_FFFF, 0, 1'b0, rd, er);
    op(1'b0, 8'h04, 2'd2, 32'h0, 0, 1'b0, rd, er); check("misaligned_wr_nop", rd, 32'h1234_BEEF);

    op(1'b0, 8'h04, 2'd2, 32'h0, 3, 1'b1, rd, er); check("stall_read", rd, 32'h1234_BEEF);
    op(1'b0, 8'h04, 2'd2, 32'h0, 0, 1'b0, rd, er); check("stall_pulse_ignored", rd, 32'h1234_BEEF);

    for (int i = 0; i < 200; i++) begin
      op(1'($urandom), 8'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 2)),
         1'b0, rd, er);
    end

    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h10; bus.req_size = 2'd2;
    bus.req_w_data = 32'hCAFE_F00D;
    model(1'b1, 8'h10, 2'd2, 32'hCAFE_F00D, rd, er);
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("resp_before_rst", {31'b0, bus.rsp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_mid_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef RAM_B_INIT_EN
    wait_init();
    op(1'b0, 8'h28, 2'd2, 32'h0, 0, 1'b0, rd, er); check("init_word_28", rd, 32'h0A0A_0A0A);
`else
    check("ready_after_rst2", {31'b0, bus.req_ready}, 32'd1);
    op(1'b0, 8'h10, 2'd2, 32'h0, 0, 1'b0, rd, er); check("commit_before_rst", rd, 32'hCAFE_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
